// File: rtl/rasengan_pkg.sv
// Shared types and constants for the 3x3 convolution stage: Q8.8 widths, FSM
// states, feature-map size decode and raster address helper.
package rasengan_pkg;

  localparam int          LENGTH    = 16;
  localparam int          FRAC_BITS = 8;
  localparam int          ADDR_W    = 14;
  localparam logic [2:0]  MAX_CODE  = 3'd5;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_TAP   = 2'd1,
    S_WRITE = 2'd2,
    S_FIN   = 2'd3
  } state_e;

  function automatic logic [7:0] side_of(input logic [2:0] code);
    return 8'd4 << code;
  endfunction

  // side is a power of two, so row*side+col is a shift with a disjoint OR
  function automatic logic [ADDR_W-1:0] raster_addr(input logic [6:0] row,
                                                    input logic [6:0] col,
                                                    input logic [2:0] code);
    return (ADDR_W'(row) << (code + 3'd2)) | ADDR_W'(col);
  endfunction

endpackage

// File: rtl/conv3x3_stage_if.sv
// Control, weight-load and memory-side signals of conv3x3_stage.
// slave = the convolution stage, master = controller/memories.
interface conv3x3_stage_if #(parameter int length = rasengan_pkg::LENGTH);
  import rasengan_pkg::*;

  logic                     start;
  logic [2:0]               size_conv;
  logic                     w_we;
  logic [3:0]               w_idx;
  logic signed [length-1:0] w_data;
  logic signed [length-1:0] t_data_in;
  logic [ADDR_W-1:0]        addr_input;
  logic signed [length-1:0] t_data_out;
  logic [ADDR_W-1:0]        addr_output;
  logic                     en_write_out;
  logic                     busy;
  logic                     done;
  logic                     err;

  modport master (
    output start, size_conv, w_we, w_idx, w_data, t_data_in,
    input  addr_input, t_data_out, addr_output, en_write_out, busy, done, err
  );

  modport slave (
    input  start, size_conv, w_we, w_idx, w_data, t_data_in,
    output addr_input, t_data_out, addr_output, en_write_out, busy, done, err
  );

endinterface

// File: rtl/conv3x3_mac.sv
// Multiply-accumulate over the nine taps, then >>>8 and saturation to Q8.8.
// Define CONV3X3_LRELU_EN to apply LeakyReLU (negative >>> 3) after saturation.
module conv3x3_mac import rasengan_pkg::*; #(
  parameter int length = LENGTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear_i,
  input  logic                     acc_en_i,
  input  logic                     valid_i,
  input  logic                     last_i,
  input  logic signed [length-1:0] weight_i,
  input  logic signed [length-1:0] pixel_i,
  output logic signed [length-1:0] result_o
);

  localparam int PROD_W = 2 * length;
  localparam int ACC_W  = PROD_W + 4;
  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-length+1){1'b0}}, {(length-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-length+1){1'b1}}, {(length-1){1'b0}}};

  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  acc_q, acc_d, shifted;
  logic signed [length-1:0] sat, res_d, res_q;

  // NOTE: every combinational output gets a default first so no path infers a latch.
  always_comb begin
    prod  = PROD_W'(weight_i) * PROD_W'(pixel_i);
    acc_d = acc_q;
    if (acc_en_i) begin
      acc_d = (clear_i ? '0 : acc_q)
            + (valid_i ? {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod} : '0);
    end
    shifted = acc_d >>> FRAC_BITS;
    if (shifted > SAT_MAX)      sat = SAT_MAX[length-1:0];
    else if (shifted < SAT_MIN) sat = SAT_MIN[length-1:0];
    else                        sat = shifted[length-1:0];
`ifdef CONV3X3_LRELU_EN
    res_d = sat[length-1] ? (sat >>> 3) : sat;
`else
    res_d = sat;
`endif
  end

  // NOTE: reset is synchronous; state registers use non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
      res_q <= '0;
    end else begin
      acc_q <= acc_d;
      if (last_i) res_q <= res_d;
    end
  end

  assign result_o = res_q;

endmodule

// File: rtl/conv3x3_stage.sv
// Same-size 3x3 convolution with zero padding over a side x side map held in an
// async-read memory. LeakyReLU output via CONV3X3_LRELU_EN (see conv3x3_mac).
module conv3x3_stage import rasengan_pkg::*; #(
  parameter int length = LENGTH
) (
  input  logic            clk,
  input  logic            rst,
  conv3x3_stage_if.slave  bus
);

  state_e                   state_q, state_d;
  logic [2:0]               code_q, code_d;
  logic [6:0]               row_q, row_d, col_q, col_d, last_rc;
  logic [1:0]               ky_q, ky_d, kx_q, kx_d;
  logic                     err_q, err_d;
  logic [ADDR_W-1:0]        addr_in_q, addr_out_q, addr_out_d, tap_addr;
  logic [8:0]               tap_r, tap_c;
  logic [7:0]               side;
  logic [3:0]               tap_idx;
  logic                     in_bounds, tap_last;
  logic signed [length-1:0] w_q [9];

  assign side     = side_of(code_q);
  assign last_rc  = 7'(side - 8'd1);
  // row-1 at row 0 wraps to 511, so one unsigned compare covers both borders
  assign tap_r    = {2'b00, row_q} + {7'b0, ky_q} - 9'd1;
  assign tap_c    = {2'b00, col_q} + {7'b0, kx_q} - 9'd1;
  assign in_bounds = (tap_r < {1'b0, side}) && (tap_c < {1'b0, side});
  assign tap_addr = raster_addr(tap_r[6:0], tap_c[6:0], code_q);
  assign tap_idx  = {2'b00, ky_q} * 4'd3 + {2'b00, kx_q};
  assign tap_last = (ky_q == 2'd2) && (kx_q == 2'd2);

  // NOTE: the weight file is storage, not control state, so it has no reset and survives rst.
  always_ff @(posedge clk) begin
    if (state_q == S_IDLE && bus.w_we && bus.w_idx < 4'd9) w_q[bus.w_idx] <= bus.w_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      code_q     <= '0;
      row_q      <= '0;
      col_q      <= '0;
      ky_q       <= '0;
      kx_q       <= '0;
      err_q      <= 1'b0;
      addr_in_q  <= '0;
      addr_out_q <= '0;
    end else begin
      state_q    <= state_d;
      code_q     <= code_d;
      row_q      <= row_d;
      col_q      <= col_d;
      ky_q       <= ky_d;
      kx_q       <= kx_d;
      err_q      <= err_d;
      addr_in_q  <= bus.addr_input;
      addr_out_q <= addr_out_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    code_d     = code_q;
    row_d      = row_q;
    col_d      = col_q;
    ky_d       = ky_q;
    kx_d       = kx_q;
    err_d      = err_q;
    addr_out_d = addr_out_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          row_d = '0;
          col_d = '0;
          ky_d  = '0;
          kx_d  = '0;
          if (bus.size_conv > MAX_CODE) begin
            err_d   = 1'b1;
            state_d = S_FIN;
          end else begin
            err_d   = 1'b0;
            code_d  = bus.size_conv;
            state_d = S_TAP;
          end
        end
      end
      S_TAP: begin
        if (tap_last) begin
          ky_d       = '0;
          kx_d       = '0;
          addr_out_d = raster_addr(row_q, col_q, code_q);
          state_d    = S_WRITE;
        end else if (kx_q == 2'd2) begin
          kx_d = '0;
          ky_d = ky_q + 2'd1;
        end else begin
          kx_d = kx_q + 2'd1;
        end
      end
      S_WRITE: begin
        state_d = S_TAP;
        if (col_q == last_rc) begin
          col_d = '0;
          if (row_q == last_rc) state_d = S_FIN;
          else                  row_d   = row_q + 7'd1;
        end else begin
          col_d = col_q + 7'd1;
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  conv3x3_mac #(.length(length)) u_mac (
    .clk      (clk),
    .rst      (rst),
    .clear_i  (ky_q == 2'd0 && kx_q == 2'd0),
    .acc_en_i (state_q == S_TAP),
    .valid_i  (in_bounds),
    .last_i   (state_q == S_TAP && tap_last),
    .weight_i (w_q[tap_idx]),
    .pixel_i  (bus.t_data_in),
    .result_o (bus.t_data_out)
  );

  // out-of-bounds taps leave the read address where it was
  assign bus.addr_input   = (state_q == S_TAP && in_bounds) ? tap_addr : addr_in_q;
  assign bus.addr_output  = addr_out_q;
  assign bus.en_write_out = (state_q == S_WRITE);
  assign bus.busy         = (state_q == S_TAP) || (state_q == S_WRITE);
  assign bus.done         = (state_q == S_FIN);
  assign bus.err          = err_q;

endmodule

// File: tb/tb_conv3x3_stage.sv
// Self-checking bench for conv3x3_stage: directed and random passes compared
// against a direct zero-padded 3x3 convolution model.
module tb_conv3x3_stage;
  import rasengan_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  conv3x3_stage_if #(.length(LENGTH)) bus ();

  conv3x3_stage #(.length(LENGTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic signed [15:0] in_mem  [16384];
  logic signed [15:0] out_mem [16384];
  logic signed [15:0] w_model [9];

  assign bus.t_data_in = in_mem[bus.addr_input];

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  always @(posedge clk) cyc <= cyc + 1;

`ifdef CONV3X3_LRELU_EN
  localparam longint SIGN_EXP = -100;
`else
  localparam longint SIGN_EXP = -800;
`endif

  task automatic check(input string tag, input logic signed [63:0] got,
                       input logic signed [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic longint ref_pixel(int side, int r, int c);
    longint acc = 0;
    int rr, cc;
    for (int ky = 0; ky < 3; ky++) begin
      for (int kx = 0; kx < 3; kx++) begin
        rr = r + ky - 1;
        cc = c + kx - 1;
        if (rr >= 0 && rr < side && cc >= 0 && cc < side)
          acc += longint'(w_model[ky*3+kx]) * longint'(in_mem[rr*side+cc]);
      end
    end
    acc = acc >>> 8;
    if (acc > 32767)       acc = 32767;
    else if (acc < -32768) acc = -32768;
`ifdef CONV3X3_LRELU_EN
    if (acc < 0) acc = acc >>> 3;
`endif
    return acc;
  endfunction

  task automatic load_weights();
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      bus.w_we = 1'b1; bus.w_idx = 4'(i); bus.w_data = w_model[i];
    end
    // out-of-range index must not alias onto a real tap
    @(negedge clk);
    bus.w_idx = 4'd12; bus.w_data = 16'sh7fff;
    @(negedge clk);
    bus.w_we = 1'b0; bus.w_idx = 4'd0; bus.w_data = '0;
  endtask

  task automatic fill(input int n, input int val);
    for (int i = 0; i < n; i++) in_mem[i] = 16'(val);
  endtask

  task automatic run_pass(input logic [2:0] code, input string tag, input bit disturb);
    int side, npix, k, nw, r, c;
    bit got_done;
    side = 4 << code;
    npix = side * side;
    nw = 0;
    got_done = 0;
    @(negedge clk);
    bus.size_conv = code; bus.start = 1'b1;
    @(posedge clk); #1;
    k = cyc;
    bus.start = 1'b0;
    for (int t = 0; t < 10*npix + 20 && !got_done; t++) begin
      @(negedge clk);
      if (t == 0) begin
        check({tag, " busy_at_start"}, bus.busy, 1);
        check({tag, " err_cleared"}, bus.err, 0);
      end
      if (disturb && t == 15) begin
        bus.start = 1'b1; bus.size_conv = 3'd7;
        bus.w_we = 1'b1; bus.w_idx = 4'd4; bus.w_data = 16'sh1234;
      end else if (disturb && t == 16) begin
        bus.start = 1'b0; bus.size_conv = code; bus.w_we = 1'b0;
      end
      if (bus.en_write_out) begin
        if (nw < npix) begin
          r = nw / side;
          c = nw % side;
          check({tag, " addr"}, bus.addr_output, nw);
          check({tag, " data"}, bus.t_data_out, ref_pixel(side, r, c));
          check({tag, " write_cycle"}, cyc + 1, k + 10 + 10*nw);
          out_mem[bus.addr_output] = bus.t_data_out;
        end
        nw++;
      end
      if (bus.done) begin
        got_done = 1;
        check({tag, " done_cycle"}, cyc + 1, k + 10*npix + 1);
        check({tag, " write_count"}, nw, npix);
        check({tag, " busy_in_fin"}, bus.busy, 0);
      end
    end
    check({tag, " done_seen"}, got_done, 1);
    @(negedge clk);
    check({tag, " done_pulse"}, bus.done, 0);
  endtask

  initial begin
    int k, nw, busy_hits, done_cyc;
    bit found;
    bus.start = 1'b0; bus.size_conv = '0; bus.w_we = 1'b0; bus.w_idx = '0; bus.w_data = '0;
    for (int i = 0; i < 16384; i++) begin in_mem[i] = '0; out_mem[i] = '0; end
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    check("rst busy", bus.busy, 0);
    check("rst done", bus.done, 0);
    check("rst en_write_out", bus.en_write_out, 0);
    check("rst err", bus.err, 0);
    check("rst addr_input", bus.addr_input, 0);
    check("rst addr_output", bus.addr_output, 0);
    check("rst t_data_out", bus.t_data_out, 0);

    // identity on 8x8
    for (int i = 0; i < 64; i++) in_mem[i] = 16'(100 + 10*i);
    for (int i = 0; i < 9; i++) w_model[i] = '0;
    w_model[4] = 16'sd256;
    load_weights();
    run_pass(3'd1, "ident", 0);
    check("ident first", out_mem[0], 100);
    check("ident last", out_mem[63], 730);

    // box sum with busy-time start/weight writes that must be ignored
    fill(16, 256);
    for (int i = 0; i < 9; i++) w_model[i] = 16'sd256;
    load_weights();
    run_pass(3'd0, "box", 1);
    check("box corner", out_mem[0], 1024);
    check("box edge", out_mem[1], 1536);
    check("box edge_col", out_mem[4], 1536);
    check("box interior", out_mem[5], 2304);
    check("box corner_last", out_mem[15], 1024);

    // positive saturation
    fill(16, 32767);
    run_pass(3'd0, "sat", 0);
    check("sat interior", out_mem[5], 32767);
    check("sat corner", out_mem[0], 32767);

    // sign path
    fill(16, 800);
    for (int i = 0; i < 9; i++) w_model[i] = '0;
    w_model[4] = -16'sd256;
    load_weights();
    run_pass(3'd0, "sign", 0);
    check("sign corner", out_mem[0], SIGN_EXP);
    check("sign interior", out_mem[5], SIGN_EXP);

    // invalid size code
    @(negedge clk);
    bus.size_conv = 3'd6; bus.start = 1'b1;
    @(posedge clk); #1;
    k = cyc; bus.start = 1'b0;
    nw = 0; done_cyc = -1;
    for (int t = 0; t < 6; t++) begin
      @(negedge clk);
      if (bus.en_write_out) nw++;
      if (bus.done && done_cyc < 0) done_cyc = cyc + 1;
    end
    check("inv done_latency_ok", (done_cyc - k >= 1) && (done_cyc - k <= 2), 1);
    check("inv err", bus.err, 1);
    check("inv writes", nw, 0);
    run_pass(3'd0, "after_inv", 0);

    // reset during pixel 5 TAP, weights kept
    for (int i = 0; i < 9; i++) w_model[i] = 16'($urandom_range(0, 1023) - 512);
    for (int i = 0; i < 16; i++) in_mem[i] = 16'($urandom_range(0, 65535));
    load_weights();
    @(negedge clk);
    bus.size_conv = 3'd0; bus.start = 1'b1;
    @(negedge clk); bus.start = 1'b0;
    nw = 0; found = 0;
    for (int t = 0; t < 200 && !found; t++) begin
      @(negedge clk);
      if (bus.en_write_out) nw++;
      if (nw == 5) found = 1;
    end
    check("rstmid reached_pixel5", found, 1);
    @(negedge clk); @(negedge clk);
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    nw = 0; busy_hits = 0;
    check("rstmid t_data_out", bus.t_data_out, 0);
    check("rstmid addr_output", bus.addr_output, 0);
    for (int t = 0; t < 40; t++) begin
      if (bus.en_write_out) nw++;
      if (bus.busy) busy_hits++;
      @(negedge clk);
    end
    check("rstmid writes_after", nw, 0);
    check("rstmid busy_after", busy_hits, 0);
    run_pass(3'd0, "post_rst", 0);

    // random passes
    for (int p = 0; p < 3; p++) begin
      for (int i = 0; i < 9; i++) w_model[i] = 16'($urandom_range(0, 65535));
      if (p == 0) for (int i = 0; i < 9; i++) w_model[i] = 16'($urandom_range(0, 767) - 384);
      for (int i = 0; i < 256; i++) in_mem[i] = 16'($urandom_range(0, 65535));
      load_weights();
      run_pass(3'(p), "rand", 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
